// File: rtl/bram_frame_copier_pkg.sv
// Shared definitions for the BRAM frame copier: FSM encodings (also used by
// the upstream copy-enable controller), default geometry and a width helper.
`timescale 1ns/1ps

package bram_frame_copier_pkg;

  // State encodings are fixed so the enable controller and this engine agree
  // on what IDLE/RUN/DRAIN look like on a debug bus or in a waveform.
  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_RUN   = 2'b01,
    ST_DRAIN = 2'b10
  } copy_state_e;

  // Default frame geometry: 320x240 RGB444 pixels.
  localparam int DEF_DATA_W     = 12;
  localparam int DEF_DEPTH      = 76800;
  localparam int DEF_RD_LATENCY = 2;

  // Width of the completed-frame counter.
  localparam int FRAME_CNT_W = 16;

  // Address width for a memory of 'depth' words; never narrower than one bit
  // so a degenerate single-word frame still has a legal address bus.
  function automatic int addr_width(input int depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

endpackage : bram_frame_copier_pkg

// File: rtl/bram_frame_copier_if.sv
// Source/destination BRAM port bundle between the copy engine and the two
// frame memories.
//
// Handshake: pure strobe semantics, no ready signals. The copier raises
// src_rd_en for exactly one cycle per word with src_rd_addr stable in that
// cycle; the source BRAM returns src_rd_data unconditionally RD_LATENCY
// cycles later. dst_wr_en is a one-cycle write strobe qualifying
// dst_wr_addr/dst_wr_data; the destination BRAM always accepts. Neither
// memory can stall the copier -- flow control happens upstream via
// copy_enable.
`timescale 1ns/1ps

interface bram_frame_copier_if #(
  parameter int ADDR_W = 17,
  parameter int DATA_W = 12
);

  logic              src_rd_en;
  logic [ADDR_W-1:0] src_rd_addr;
  logic [DATA_W-1:0] src_rd_data;
  logic              dst_wr_en;
  logic [ADDR_W-1:0] dst_wr_addr;
  logic [DATA_W-1:0] dst_wr_data;

  // Copy engine side.
  modport master (
    output src_rd_en,
    output src_rd_addr,
    input  src_rd_data,
    output dst_wr_en,
    output dst_wr_addr,
    output dst_wr_data
  );

  // Memory side (source read port + destination write port).
  modport slave (
    input  src_rd_en,
    input  src_rd_addr,
    output src_rd_data,
    input  dst_wr_en,
    input  dst_wr_addr,
    input  dst_wr_data
  );

endinterface : bram_frame_copier_if

// File: rtl/bram_frame_copier_delay_line.sv
// copy_delay_line: N-stage shift register carrying {valid, addr} alongside
// the source BRAM read so the write address lines up with the returned data.
// Bit W-1 of every stage is its valid flag.
`timescale 1ns/1ps

module copy_delay_line #(
  parameter int W = 18,
  parameter int N = 2
) (
  input  logic         clk,
  input  logic         n_rst,
  input  logic [W-1:0] d_i,
  output logic [W-1:0] q_o,
  output logic         any_valid_o
);

  logic [W-1:0] stage_q [N];

  // Shift one stage per clock; reset clears every stage so in-flight
  // words are dropped rather than written after reset.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      for (int i = 0; i < N; i++) begin
        stage_q[i] <= '0;
      end
    end else begin
      stage_q[0] <= d_i;
      for (int i = 1; i < N; i++) begin
        stage_q[i] <= stage_q[i-1];
      end
    end
  end

  // Any stage still holding a valid word means a write is still owed.
  always_comb begin
    any_valid_o = 1'b0;
    for (int i = 0; i < N; i++) begin
      any_valid_o = any_valid_o | stage_q[i][W-1];
    end
  end

  assign q_o = stage_q[N-1];

endmodule : copy_delay_line

// File: rtl/bram_frame_copier.sv
// bram_frame_copier: sweeps the source frame BRAM one word per cycle while
// copy_enable is high and writes each returned word to the same address of
// the destination BRAM RD_LATENCY cycles later. Dropping copy_enable drains
// the in-flight reads and holds the read pointer, so copying resumes at the
// next unread word with nothing skipped or repeated. Each write of the last
// address pulses frame_done and bumps frame_count.
`timescale 1ns/1ps

module bram_frame_copier
  import bram_frame_copier_pkg::*;
#(
  parameter int DATA_W     = DEF_DATA_W,
  parameter int DEPTH      = DEF_DEPTH,
  parameter int RD_LATENCY = DEF_RD_LATENCY
) (
  input  logic                   clk,
  input  logic                   n_rst,
  input  logic                   copy_enable,
  bram_frame_copier_if.master    bus,
  output logic                   frame_done,
  output logic [FRAME_CNT_W-1:0] frame_count,
  output logic                   busy,
  output copy_state_e            dbg_state_o
);

  // Derived from DEPTH only; deliberately not a parameter.
  localparam int                ADDR_W    = addr_width(DEPTH);
  localparam int                PIPE_W    = ADDR_W + 1;
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);

  copy_state_e state_q, state_d;

  logic [ADDR_W-1:0]      rd_addr_q, rd_addr_d;
  logic [FRAME_CNT_W-1:0] frame_count_q, frame_count_d;

  logic              rd_en;
  logic [PIPE_W-1:0] pipe_in;
  logic [PIPE_W-1:0] pipe_out;
  logic              pipe_busy;
  logic              wr_valid;
  logic [ADDR_W-1:0] wr_addr;
  logic [DATA_W-1:0] wr_data;

  // ---------------------------------------------------------------------
  // FSM
  // ---------------------------------------------------------------------

  // State register.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next state and read strobe. The read strobe is combinational on
  // state and copy_enable so a dropped enable stops reads in that very
  // cycle. DRAIN refuses to restart until the pipe is empty, which keeps
  // the read/write ordering trivially in address order.
  always_comb begin
    state_d = state_q;
    rd_en   = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (copy_enable) begin
          state_d = ST_RUN;
        end
      end
      ST_RUN: begin
        if (copy_enable) begin
          rd_en = 1'b1;
        end else begin
          state_d = ST_DRAIN;
        end
      end
      ST_DRAIN: begin
        if (!pipe_busy) begin
          state_d = copy_enable ? ST_RUN : ST_IDLE;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // ---------------------------------------------------------------------
  // Read address counter
  // ---------------------------------------------------------------------

  // Advance only on an issued read; held across DRAIN/IDLE so a pause
  // resumes at the next unread word. Wraps with no bubble between frames.
  always_comb begin
    rd_addr_d = rd_addr_q;
    if (rd_en) begin
      rd_addr_d = (rd_addr_q == LAST_ADDR) ? '0 : rd_addr_q + ADDR_W'(1);
    end
  end

  // Read address register.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      rd_addr_q <= '0;
    end else begin
      rd_addr_q <= rd_addr_d;
    end
  end

  // ---------------------------------------------------------------------
  // Read-to-write alignment pipe
  // ---------------------------------------------------------------------

  assign pipe_in = {rd_en, rd_addr_q};

  copy_delay_line #(
    .W (PIPE_W),
    .N (RD_LATENCY)
  ) u_delay (
    .clk         (clk),
    .n_rst       (n_rst),
    .d_i         (pipe_in),
    .q_o         (pipe_out),
    .any_valid_o (pipe_busy)
  );

  assign wr_valid = pipe_out[PIPE_W-1];
  assign wr_addr  = pipe_out[ADDR_W-1:0];

  // Data passes straight through from the source BRAM; it is zeroed when
  // no write is in progress so idle/reset outputs read as all-zero.
  assign wr_data = wr_valid ? bus.src_rd_data : '0;

  // ---------------------------------------------------------------------
  // Frame completion
  // ---------------------------------------------------------------------

  assign frame_done    = wr_valid && (wr_addr == LAST_ADDR);
  assign frame_count_d = frame_count_q + FRAME_CNT_W'(1);

  // Completed-frame counter; wraps naturally at its width.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      frame_count_q <= '0;
    end else if (frame_done) begin
      frame_count_q <= frame_count_d;
    end
  end

  // ---------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------

  assign bus.src_rd_en   = rd_en;
  assign bus.src_rd_addr = rd_addr_q;
  assign bus.dst_wr_en   = wr_valid;
  assign bus.dst_wr_addr = wr_addr;
  assign bus.dst_wr_data = wr_data;

  assign frame_count = frame_count_q;
  assign busy        = (state_q != ST_IDLE);
  assign dbg_state_o = state_q;

  // ---------------------------------------------------------------------
  // Embedded checks
  // ---------------------------------------------------------------------

  // Reads only ever issue from RUN with the enable present.
  a_rd_only_in_run : assert property (
    @(posedge clk) disable iff (!n_rst)
    bus.src_rd_en |-> (state_q == ST_RUN) && copy_enable
  );

  // A frame can only complete on a real write.
  a_done_needs_write : assert property (
    @(posedge clk) disable iff (!n_rst)
    frame_done |-> bus.dst_wr_en
  );

endmodule : bram_frame_copier

// File: tb/tb_bram_frame_copier.sv
// Directed bench for bram_frame_copier with an 8-word frame and a
// two-cycle source BRAM whose data is addr + 0x100.
`timescale 1ns/1ps

module tb_bram_frame_copier;
  import bram_frame_copier_pkg::*;

  localparam int AW    = 3;
  localparam int DW    = 12;
  localparam int DEPTH = 8;
  localparam int RDL   = 2;
  localparam int EW    = 32 + AW;

  // ---------------------------------------------------------------------
  // Clock / reset / DUT
  // ---------------------------------------------------------------------
  logic        clk;
  logic        n_rst;
  logic        copy_enable;
  logic        frame_done;
  logic [15:0] frame_count;
  logic        busy;
  copy_state_e dbg_state;

  bram_frame_copier_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();

  bram_frame_copier #(
    .DATA_W     (DW),
    .DEPTH      (DEPTH),
    .RD_LATENCY (RDL)
  ) dut (
    .clk         (clk),
    .n_rst       (n_rst),
    .copy_enable (copy_enable),
    .bus         (bus),
    .frame_done  (frame_done),
    .frame_count (frame_count),
    .busy        (busy),
    .dbg_state_o (dbg_state)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Source BRAM model: two-cycle read latency, data = addr + 0x100.
  logic [AW-1:0] mdl_a0 = '0;
  logic [AW-1:0] mdl_a1 = '0;
  always @(posedge clk) begin
    mdl_a0 <= bus.src_rd_addr;
    mdl_a1 <= mdl_a0;
  end
  assign bus.src_rd_data = DW'(mdl_a1) + 12'h100;

  // ---------------------------------------------------------------------
  // Scoreboard state
  // ---------------------------------------------------------------------
  int            checks = 0;
  int            errors = 0;
  int            cyc = 0;
  logic [EW-1:0] exp_q [$];
  logic [AW-1:0] exp_rd_next = '0;
  logic [AW-1:0] last_rd_addr = '0;
  int            rd_total = 0;
  logic [15:0]   exp_fc = '0;
  int            done_cyc [$];
  int            wr_cnt [DEPTH];
  logic [DW-1:0] dst_mem [DEPTH];

  typedef struct {
    logic          ce;
    logic          rd_en;
    logic [AW-1:0] rd_addr;
    logic          wr_en;
    logic [AW-1:0] wr_addr;
    logic [DW-1:0] wr_data;
    logic          done;
    logic          busy;
  } vec_t;

  vec_t vecs [11];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at cycle %0d: actual=%0h required=%0h", name, cyc, act, exp);
    end
  endtask

  task automatic clear_dst();
    for (int a = 0; a < DEPTH; a++) begin
      wr_cnt[a]  = 0;
      dst_mem[a] = '0;
    end
  endtask

  // Called at the falling edge: compares outputs with the expected-write
  // queue and records newly issued reads.
  task automatic sample();
    logic          exp_wr;
    logic [AW-1:0] ea;
    logic [DW-1:0] ed;
    check("frame_count", 32'(frame_count), 32'(exp_fc));
    while (exp_q.size() > 0 && int'(exp_q[0][EW-1:AW]) < cyc) begin
      check("wr_missed_cycle", cyc, 32'(exp_q[0][EW-1:AW]));
      void'(exp_q.pop_front());
    end
    exp_wr = (exp_q.size() > 0) && (int'(exp_q[0][EW-1:AW]) == cyc);
    ea     = exp_wr ? exp_q[0][AW-1:0] : '0;
    ed     = DW'(ea) + 12'h100;
    check("dst_wr_en", 32'(bus.dst_wr_en), 32'(exp_wr));
    if (exp_wr && bus.dst_wr_en) begin
      check("dst_wr_addr", 32'(bus.dst_wr_addr), 32'(ea));
      check("dst_wr_data", 32'(bus.dst_wr_data), 32'(ed));
      wr_cnt[ea]++;
      dst_mem[ea] = bus.dst_wr_data;
      void'(exp_q.pop_front());
      if (ea == AW'(DEPTH - 1)) exp_fc++;
    end
    check("frame_done", 32'(frame_done), 32'(exp_wr && (ea == AW'(DEPTH - 1))));
    if (frame_done) done_cyc.push_back(cyc);
    if (bus.src_rd_en) begin
      check("src_rd_addr", 32'(bus.src_rd_addr), 32'(exp_rd_next));
      exp_q.push_back({32'(cyc + RDL), bus.src_rd_addr});
      exp_rd_next  = (exp_rd_next == AW'(DEPTH - 1)) ? '0 : exp_rd_next + 1'b1;
      last_rd_addr = bus.src_rd_addr;
      rd_total++;
    end
    cyc++;
  endtask

  // ---------------------------------------------------------------------
  // Driver tasks
  // ---------------------------------------------------------------------
  task automatic tick();
    @(negedge clk);
    sample();
    @(posedge clk);
    #1;
  endtask

  // Keep copying until the read of address (target-1) has just issued.
  task automatic run_until_rd(input logic [AW-1:0] target);
    int r0;
    r0 = rd_total;
    copy_enable = 1'b1;
    for (int i = 0; i < 40; i++) begin
      tick();
      if (rd_total > r0 && exp_rd_next == target) break;
    end
    check("run_until_rd", 32'(exp_rd_next), 32'(target));
  endtask

  // Drop the enable and wait (bounded) for the engine to go idle.
  task automatic drain();
    copy_enable = 1'b0;
    for (int i = 0; i < 12; i++) begin
      tick();
      if (!busy) break;
    end
    check("drain_busy", 32'(busy), 32'd0);
    check("drain_state", 32'(dbg_state), 32'(ST_IDLE));
    check("drain_inflight", exp_q.size(), 32'd0);
  endtask

  task automatic check_full_pass(input string tag, input int per_addr);
    for (int a = 0; a < DEPTH; a++) begin
      check({tag, "_wr_cnt"}, wr_cnt[a], per_addr);
      check({tag, "_mem"}, 32'(dst_mem[a]), 32'(DW'(a) + 12'h100));
    end
  endtask

  // ---------------------------------------------------------------------
  // Test sequence
  // ---------------------------------------------------------------------
  initial begin
    int d0;
    int r0;
    clear_dst();

    //                ce    rd   rd_addr wr   wr_addr wr_data  done busy
    vecs[0]  = '{1'b1, 1'b0, 3'd0, 1'b0, 3'd0, 12'h000, 1'b0, 1'b0};
    vecs[1]  = '{1'b1, 1'b1, 3'd0, 1'b0, 3'd0, 12'h000, 1'b0, 1'b1};
    vecs[2]  = '{1'b1, 1'b1, 3'd1, 1'b0, 3'd0, 12'h000, 1'b0, 1'b1};
    vecs[3]  = '{1'b1, 1'b1, 3'd2, 1'b1, 3'd0, 12'h100, 1'b0, 1'b1};
    vecs[4]  = '{1'b1, 1'b1, 3'd3, 1'b1, 3'd1, 12'h101, 1'b0, 1'b1};
    vecs[5]  = '{1'b1, 1'b1, 3'd4, 1'b1, 3'd2, 12'h102, 1'b0, 1'b1};
    vecs[6]  = '{1'b1, 1'b1, 3'd5, 1'b1, 3'd3, 12'h103, 1'b0, 1'b1};
    vecs[7]  = '{1'b1, 1'b1, 3'd6, 1'b1, 3'd4, 12'h104, 1'b0, 1'b1};
    vecs[8]  = '{1'b1, 1'b1, 3'd7, 1'b1, 3'd5, 12'h105, 1'b0, 1'b1};
    vecs[9]  = '{1'b1, 1'b1, 3'd0, 1'b1, 3'd6, 12'h106, 1'b0, 1'b1};
    vecs[10] = '{1'b1, 1'b1, 3'd1, 1'b1, 3'd7, 12'h107, 1'b1, 1'b1};

    // Reset: every output must be zero.
    n_rst       = 1'b0;
    copy_enable = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_src_rd_en", 32'(bus.src_rd_en), 32'd0);
    check("rst_src_rd_addr", 32'(bus.src_rd_addr), 32'd0);
    check("rst_dst_wr_en", 32'(bus.dst_wr_en), 32'd0);
    check("rst_dst_wr_addr", 32'(bus.dst_wr_addr), 32'd0);
    check("rst_dst_wr_data", 32'(bus.dst_wr_data), 32'd0);
    check("rst_frame_done", 32'(frame_done), 32'd0);
    check("rst_frame_count", 32'(frame_count), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_state", 32'(dbg_state), 32'(ST_IDLE));
    @(posedge clk);
    #1;
    n_rst = 1'b1;
    cyc   = 0;

    // Test 1: cycle-exact first frame from reset release.
    for (int i = 0; i < 11; i++) begin
      copy_enable = vecs[i].ce;
      @(negedge clk);
      check("t1_rd_en", 32'(bus.src_rd_en), 32'(vecs[i].rd_en));
      if (vecs[i].rd_en) check("t1_rd_addr", 32'(bus.src_rd_addr), 32'(vecs[i].rd_addr));
      check("t1_wr_en", 32'(bus.dst_wr_en), 32'(vecs[i].wr_en));
      if (vecs[i].wr_en) begin
        check("t1_wr_addr", 32'(bus.dst_wr_addr), 32'(vecs[i].wr_addr));
        check("t1_wr_data", 32'(bus.dst_wr_data), 32'(vecs[i].wr_data));
      end
      check("t1_done", 32'(frame_done), 32'(vecs[i].done));
      check("t1_busy", 32'(busy), 32'(vecs[i].busy));
      sample();
      @(posedge clk);
      #1;
    end
    check("t1_frame_count", 32'(frame_count), 32'd1);

    // Test 2: 20 more enabled cycles, frames must be gapless.
    copy_enable = 1'b1;
    repeat (20) tick();
    check("t2_done_pulses", done_cyc.size(), 32'd3);
    if (done_cyc.size() == 3) begin
      check("t2_first_done_cycle", done_cyc[0], 32'd10);
      check("t2_done_spacing_a", done_cyc[1] - done_cyc[0], 32'd8);
      check("t2_done_spacing_b", done_cyc[2] - done_cyc[1], 32'd8);
    end
    check("t2_frame_count", 32'(frame_count), 32'd3);

    // Test 3: pause after reads 0..3, resume at 4.
    run_until_rd(3'd0);
    drain();
    clear_dst();
    run_until_rd(3'd4);
    drain();
    for (int a = 0; a < 4; a++) begin
      check("t3_first_half_cnt", wr_cnt[a], 32'd1);
      check("t3_second_half_untouched", wr_cnt[a + 4], 32'd0);
    end
    r0 = rd_total;
    copy_enable = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      if (rd_total > r0) break;
    end
    check("t3_resume_read_seen", rd_total, r0 + 1);
    check("t3_resume_addr", 32'(last_rd_addr), 32'd4);
    run_until_rd(3'd0);
    drain();
    check_full_pass("t3", 1);

    // Test 4: enable toggling every cycle, then a 1,1,0 pattern.
    clear_dst();
    for (int i = 0; i < 40; i++) begin
      copy_enable = (i % 2 == 0);
      tick();
    end
    for (int i = 0; i < 39; i++) begin
      copy_enable = (i % 3 != 2);
      tick();
    end
    if (exp_rd_next != 3'd0) run_until_rd(3'd0);
    drain();
    check("t4_some_writes", 32'(wr_cnt[0] > 0), 32'd1);
    check_full_pass("t4", wr_cnt[0]);

    // Test 5: async reset with two reads in flight.
    run_until_rd(3'd3);
    n_rst = 1'b0;
    #1;
    check("t5_wr_en_in_reset", 32'(bus.dst_wr_en), 32'd0);
    check("t5_rd_en_in_reset", 32'(bus.src_rd_en), 32'd0);
    check("t5_busy_in_reset", 32'(busy), 32'd0);
    check("t5_frame_count_in_reset", 32'(frame_count), 32'd0);
    exp_q.delete();
    exp_rd_next = '0;
    exp_fc      = '0;
    copy_enable = 1'b0;
    tick();
    tick();
    n_rst       = 1'b1;
    copy_enable = 1'b1;
    r0 = rd_total;
    tick();
    tick();
    check("t5_first_read_count", rd_total, r0 + 1);
    check("t5_first_read_addr", 32'(last_rd_addr), 32'd0);
    check("t5_frame_count", 32'(frame_count), 32'd0);
    drain();

    // Test 6: frame counter wrap.
    force dut.frame_count_q = 16'hFFFF;
    exp_fc = 16'hFFFF;
    tick();
    release dut.frame_count_q;
    tick();
    check("t6_preset", 32'(frame_count), 32'h0000FFFF);
    d0 = done_cyc.size();
    copy_enable = 1'b1;
    for (int i = 0; i < 30; i++) begin
      tick();
      if (done_cyc.size() > d0) break;
    end
    drain();
    check("t6_single_done", done_cyc.size(), d0 + 1);
    check("t6_wrapped", 32'(frame_count), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  // Hard stop in case the sequence itself stalls.
  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, errors=%0d", errors);
    $fatal(1);
  end

endmodule : tb_bram_frame_copier
